// File: rtl/cpu_control.sv
// rtl/cpu_control.sv - SM83 microcoded control unit: opcode/step tracking and datapath control decode
module cpu_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] t_cycle,
  input  logic [7:0] mem_data_in,
  input  logic       condition,
  output logic [1:0] pc_next,
  output logic       inst_load,
  output logic [3:0] reg_read1_sel,
  output logic [3:0] reg_read2_sel,
  output logic [3:0] reg_write_sel,
  output logic [1:0] reg_op,
  output logic [1:0] inc_op,
  output logic [1:0] inc_reg,
  output logic [1:0] alu_op,
  output logic       alu_sel_a,
  output logic       alu_sel_b,
  output logic       alu_write_flags,
  output logic       mem_enable,
  output logic       mem_write,
  output logic [1:0] mem_addr_sel
);

  typedef enum logic [1:0] {STEP_0, STEP_1, STEP_2, STEP_3} step_e;

  localparam logic [1:0] PC_SAME = 2'd0, PC_INC = 2'd1, PC_REG = 2'd2;
  localparam logic [3:0] SEL_A = 4'd0, SEL_C = 4'd1, SEL_W = 4'd2, SEL_Z = 4'd3;
  localparam logic [3:0] SEL_SRC = 4'd6, SEL_DEST = 4'd7, SEL_R16HI = 4'd8, SEL_R16LO = 4'd9;
  localparam logic [1:0] REG_NONE = 2'd0, REG_WR_ALU = 2'd1, REG_WR_MEM = 2'd2;
  localparam logic [1:0] INC_NONE = 2'd0, INC_INC = 2'd1, INC_DEC = 2'd2;
  localparam logic [1:0] IREG_HL = 2'd0, IREG_INST16 = 2'd3;
  localparam logic [1:0] ALU_COPYA = 2'd0, ALU_COPYB = 2'd1, ALU_INST = 2'd3;
  localparam logic [1:0] ADDR_PC = 2'd0, ADDR_HL = 2'd1, ADDR_HIGH = 2'd3;

  logic [7:0] op_q, op_d;
  step_e      step_q, step_d;
  step_e      last_step;

  // Opcode class decode; (HL) operand is encoded as register index 6
  logic src_hl, dst_hl;
  logic ld_rr, ld_r_hl, ld_hl_r, ld_r_n, ld_hl_n;
  logic alu_r, alu_hl, alu_n;
  logic ld_r16, inc16, dec16;
  logic ld_hli_a, ld_hld_a, ld_a_hli, ld_a_hld;
  logic ldh_n_a, ldh_a_n, ld_c_a, ld_a_c, jp, jpcc;

  assign src_hl   = (op_q[2:0] == 3'd6);
  assign dst_hl   = (op_q[5:3] == 3'd6);
  assign ld_rr    = (op_q[7:6] == 2'b01) && !src_hl && !dst_hl;
  assign ld_r_hl  = (op_q[7:6] == 2'b01) &&  src_hl && !dst_hl;
  assign ld_hl_r  = (op_q[7:6] == 2'b01) && !src_hl &&  dst_hl;
  assign ld_r_n   = (op_q[7:6] == 2'b00) &&  src_hl && !dst_hl;
  assign ld_hl_n  = (op_q == 8'h36);
  assign alu_r    = (op_q[7:6] == 2'b10) && !src_hl;
  assign alu_hl   = (op_q[7:6] == 2'b10) &&  src_hl;
  assign alu_n    = (op_q[7:6] == 2'b11) &&  src_hl;
  assign ld_r16   = (op_q[7:6] == 2'b00) && (op_q[3:0] == 4'h1);
  assign inc16    = (op_q[7:6] == 2'b00) && (op_q[3:0] == 4'h3);
  assign dec16    = (op_q[7:6] == 2'b00) && (op_q[3:0] == 4'hB);
  assign ld_hli_a = (op_q == 8'h22);
  assign ld_hld_a = (op_q == 8'h32);
  assign ld_a_hli = (op_q == 8'h2A);
  assign ld_a_hld = (op_q == 8'h3A);
  assign ldh_n_a  = (op_q == 8'hE0);
  assign ldh_a_n  = (op_q == 8'hF0);
  assign ld_c_a   = (op_q == 8'hE2);
  assign ld_a_c   = (op_q == 8'hF2);
  assign jp       = (op_q == 8'hC3);
  assign jpcc     = (op_q == 8'hC2) || (op_q == 8'hCA) || (op_q == 8'hD2) || (op_q == 8'hDA);

  assign alu_sel_a = 1'b0;
  assign alu_sel_b = 1'b0;

  // Step index at which the instruction fetches the next opcode
  always_comb begin
    last_step = STEP_0;
    if (jp || jpcc)
      last_step = STEP_3;
    else if (ld_hl_n || ld_r16 || ldh_n_a || ldh_a_n)
      last_step = STEP_2;
    else if (ld_r_hl || ld_hl_r || ld_r_n || alu_hl || alu_n || inc16 || dec16 ||
             ld_hli_a || ld_hld_a || ld_a_hli || ld_a_hld || ld_c_a || ld_a_c)
      last_step = STEP_1;
  end

  // Opcode and step registers; reset leaves a NOP so the first step is a fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= 8'h00;
      step_q <= STEP_0;
    end else begin
      op_q   <= op_d;
      step_q <= step_d;
    end
  end

  // Step sequencing at the end of each M-cycle; a failed JP cc skips the jump step
  always_comb begin
    op_d   = op_q;
    step_d = step_q;
    if (t_cycle == 2'd3) begin
      if (step_q == last_step) begin
        op_d   = mem_data_in;
        step_d = STEP_0;
      end else if (jpcc && (step_q == STEP_1) && !condition) begin
        step_d = STEP_3;
      end else begin
        case (step_q)
          STEP_0:  step_d = STEP_1;
          STEP_1:  step_d = STEP_2;
          default: step_d = STEP_3;
        endcase
      end
    end
  end

  // Control word for the current (opcode, step)
  always_comb begin
    pc_next         = PC_SAME;
    inst_load       = 1'b0;
    reg_read1_sel   = SEL_A;
    reg_read2_sel   = SEL_A;
    reg_write_sel   = SEL_A;
    reg_op          = REG_NONE;
    inc_op          = INC_NONE;
    inc_reg         = IREG_HL;
    alu_op          = ALU_COPYA;
    alu_write_flags = 1'b0;
    mem_enable      = 1'b0;
    mem_write       = 1'b0;
    mem_addr_sel    = ADDR_PC;
    if (step_q == last_step) begin
      mem_enable   = 1'b1;
      mem_addr_sel = ADDR_PC;
      pc_next      = PC_INC;
      inst_load    = 1'b1;
      if (ld_rr) begin
        reg_read2_sel = SEL_SRC;
        alu_op        = ALU_COPYB;
        reg_op        = REG_WR_ALU;
        reg_write_sel = SEL_DEST;
      end else if (alu_r || alu_hl || alu_n) begin
        reg_read2_sel   = alu_r ? SEL_SRC : SEL_Z;
        alu_op          = ALU_INST;
        reg_op          = REG_WR_ALU;
        reg_write_sel   = SEL_A;
        alu_write_flags = 1'b1;
      end
    end else if (step_q == STEP_0) begin
      if (ld_r_hl || alu_hl || ld_a_hli || ld_a_hld) begin
        mem_enable    = 1'b1;
        mem_addr_sel  = ADDR_HL;
        reg_op        = REG_WR_MEM;
        reg_write_sel = ld_r_hl ? SEL_DEST : (alu_hl ? SEL_Z : SEL_A);
        if (ld_a_hli || ld_a_hld) begin
          inc_reg = IREG_HL;
          inc_op  = ld_a_hli ? INC_INC : INC_DEC;
        end
      end else if (ld_hl_r || ld_hli_a || ld_hld_a) begin
        mem_enable   = 1'b1;
        mem_write    = 1'b1;
        mem_addr_sel = ADDR_HL;
        if (ld_hl_r) begin
          reg_read2_sel = SEL_SRC;
          alu_op        = ALU_COPYB;
        end else begin
          alu_op  = ALU_COPYA;
          inc_reg = IREG_HL;
          inc_op  = ld_hli_a ? INC_INC : INC_DEC;
        end
      end else if (ld_r_n || ld_hl_n || alu_n || ld_r16 || ldh_n_a || ldh_a_n || jp || jpcc) begin
        mem_enable    = 1'b1;
        mem_addr_sel  = ADDR_PC;
        pc_next       = PC_INC;
        reg_op        = REG_WR_MEM;
        reg_write_sel = ld_r_n ? SEL_DEST : (ld_r16 ? SEL_R16LO : SEL_Z);
      end else if (inc16 || dec16) begin
        inc_reg = IREG_INST16;
        inc_op  = inc16 ? INC_INC : INC_DEC;
      end else if (ld_c_a || ld_a_c) begin
        mem_enable    = 1'b1;
        mem_addr_sel  = ADDR_HIGH;
        reg_read2_sel = SEL_C;
        if (ld_c_a) begin
          mem_write = 1'b1;
          alu_op    = ALU_COPYA;
        end else begin
          reg_op        = REG_WR_MEM;
          reg_write_sel = SEL_A;
        end
      end
    end else if (step_q == STEP_1) begin
      if (ld_hl_n) begin
        mem_enable    = 1'b1;
        mem_write     = 1'b1;
        mem_addr_sel  = ADDR_HL;
        reg_read2_sel = SEL_Z;
        alu_op        = ALU_COPYB;
      end else if (ld_r16 || jp || jpcc) begin
        mem_enable    = 1'b1;
        mem_addr_sel  = ADDR_PC;
        pc_next       = PC_INC;
        reg_op        = REG_WR_MEM;
        reg_write_sel = ld_r16 ? SEL_R16HI : SEL_W;
      end else if (ldh_n_a || ldh_a_n) begin
        mem_enable    = 1'b1;
        mem_addr_sel  = ADDR_HIGH;
        reg_read2_sel = SEL_Z;
        if (ldh_n_a) begin
          mem_write = 1'b1;
          alu_op    = ALU_COPYA;
        end else begin
          reg_op        = REG_WR_MEM;
          reg_write_sel = SEL_A;
        end
      end
    end else begin
      if (jp || jpcc) begin
        reg_read1_sel = SEL_W;
        reg_read2_sel = SEL_Z;
        pc_next       = PC_REG;
      end
    end
  end

endmodule

// File: tb/tb_cpu_control.sv
// tb/tb_cpu_control.sv - directed scoreboard bench for cpu_control
module tb_cpu_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] t_cycle = 2'd0;
  logic [7:0] mem_data_in = 8'h00;
  logic       condition = 1'b0;
  logic [1:0] pc_next;
  logic       inst_load;
  logic [3:0] reg_read1_sel, reg_read2_sel, reg_write_sel;
  logic [1:0] reg_op, inc_op, inc_reg, alu_op;
  logic       alu_sel_a, alu_sel_b, alu_write_flags;
  logic       mem_enable, mem_write;
  logic [1:0] mem_addr_sel;

  typedef struct packed {
    logic [1:0] pc_next;
    logic       inst_load;
    logic [3:0] r1;
    logic [3:0] r2;
    logic [3:0] wr;
    logic [1:0] reg_op;
    logic [1:0] inc_op;
    logic [1:0] inc_reg;
    logic [1:0] alu_op;
    logic       sel_a;
    logic       sel_b;
    logic       wflags;
    logic       men;
    logic       mwr;
    logic [1:0] addr;
  } ctl_t;

  ctl_t  obs;
  ctl_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    failures = 0;

  cpu_control dut (
    .clk(clk), .reset(reset), .t_cycle(t_cycle), .mem_data_in(mem_data_in),
    .condition(condition), .pc_next(pc_next), .inst_load(inst_load),
    .reg_read1_sel(reg_read1_sel), .reg_read2_sel(reg_read2_sel),
    .reg_write_sel(reg_write_sel), .reg_op(reg_op), .inc_op(inc_op),
    .inc_reg(inc_reg), .alu_op(alu_op), .alu_sel_a(alu_sel_a), .alu_sel_b(alu_sel_b),
    .alu_write_flags(alu_write_flags), .mem_enable(mem_enable), .mem_write(mem_write),
    .mem_addr_sel(mem_addr_sel)
  );

  assign obs = {pc_next, inst_load, reg_read1_sel, reg_read2_sel, reg_write_sel,
                reg_op, inc_op, inc_reg, alu_op, alu_sel_a, alu_sel_b,
                alu_write_flags, mem_enable, mem_write, mem_addr_sel};

  always #5 clk = ~clk;

  function automatic ctl_t fetch_e();
    ctl_t e = '0;
    e.pc_next   = 2'd1;
    e.inst_load = 1'b1;
    e.men       = 1'b1;
    return e;
  endfunction

  function automatic ctl_t rdpc_e(input logic [3:0] dst);
    ctl_t e = '0;
    e.pc_next = 2'd1;
    e.men     = 1'b1;
    e.reg_op  = 2'd2;
    e.wr      = dst;
    return e;
  endfunction

  task automatic expect_next(input string tag, input ctl_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic check_pop();
    ctl_t  e;
    string tag;
    e   = exp_q.pop_front();
    tag = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // One M-cycle: expectation queued with the stimulus, compared mid-step
  task automatic mstep(input string tag, input logic [7:0] d, input logic c, input ctl_t e);
    expect_next(tag, e);
    mem_data_in = d;
    condition   = c;
    for (int t = 0; t < 4; t++) begin
      t_cycle = 2'(t);
      @(negedge clk);
      if (t == 0) check_pop();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    ctl_t e;
    // reset held: fetch signals
    #2;
    expect_next("reset_hold", fetch_e());
    check_pop();
    @(posedge clk); #1;
    reset = 1'b0;

    mstep("nop_fetch0", 8'h00, 1'b0, fetch_e());
    mstep("nop_fetch1", 8'h78, 1'b0, fetch_e());
    e = fetch_e(); e.r2 = 4'd6; e.alu_op = 2'd1; e.reg_op = 2'd1; e.wr = 4'd7;
    mstep("ld_a_b_f", 8'h86, 1'b0, e);
    e = '0; e.men = 1'b1; e.addr = 2'd1; e.reg_op = 2'd2; e.wr = 4'd3;
    mstep("add_hl_s0", 8'h55, 1'b0, e);
    e = fetch_e(); e.alu_op = 2'd3; e.r2 = 4'd3; e.reg_op = 2'd1; e.wr = 4'd0; e.wflags = 1'b1;
    mstep("add_hl_f", 8'hC3, 1'b0, e);
    mstep("jp_s0", 8'h34, 1'b0, rdpc_e(4'd3));
    mstep("jp_s1", 8'h12, 1'b0, rdpc_e(4'd2));
    e = '0; e.pc_next = 2'd2; e.r1 = 4'd2; e.r2 = 4'd3;
    mstep("jp_s2", 8'h55, 1'b0, e);
    mstep("jp_f", 8'hC2, 1'b0, fetch_e());
    mstep("jpnc_s0", 8'h00, 1'b0, rdpc_e(4'd3));
    mstep("jpnc_s1", 8'h00, 1'b0, rdpc_e(4'd2));
    mstep("jpnc_skip_f", 8'hC2, 1'b1, fetch_e());
    mstep("jpc_s0", 8'h00, 1'b1, rdpc_e(4'd3));
    mstep("jpc_s1", 8'h00, 1'b1, rdpc_e(4'd2));
    e = '0; e.pc_next = 2'd2; e.r1 = 4'd2; e.r2 = 4'd3;
    mstep("jpc_s2", 8'h00, 1'b1, e);
    mstep("jpc_f", 8'hE0, 1'b0, fetch_e());
    mstep("ldh_s0", 8'h80, 1'b0, rdpc_e(4'd3));

    // LDH S1, then reset mid-step aborts it
    e = '0; e.men = 1'b1; e.mwr = 1'b1; e.addr = 2'd3; e.r2 = 4'd3; e.alu_op = 2'd0;
    expect_next("ldh_s1", e);
    t_cycle = 2'd0;
    @(negedge clk);
    check_pop();
    @(posedge clk); #1;
    t_cycle = 2'd1;
    #2;
    reset = 1'b1;
    #1;
    expect_next("reset_abort", fetch_e());
    check_pop();
    @(posedge clk); #1;
    reset = 1'b0;

    mstep("post_reset_f", 8'h22, 1'b0, fetch_e());
    e = '0; e.men = 1'b1; e.mwr = 1'b1; e.addr = 2'd1; e.inc_reg = 2'd0; e.inc_op = 2'd1;
    mstep("ld_hli_a_s0", 8'h00, 1'b0, e);
    mstep("ld_hli_a_f", 8'h0B, 1'b0, fetch_e());
    e = '0; e.inc_reg = 2'd3; e.inc_op = 2'd2;
    mstep("dec_bc_s0", 8'h00, 1'b0, e);
    mstep("dec_bc_f", 8'h76, 1'b0, fetch_e());
    mstep("halt_f", 8'h00, 1'b0, fetch_e());
    mstep("nop_final", 8'h00, 1'b0, fetch_e());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
